// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if
// Bundles the two producer valid/ready streams and the FIFO write-side
// signals that the round-robin write arbiter sits between.
//
// Signals:
//   s0_valid, s0_data, s0_ready : producer channel 0 stream
//   s1_valid, s1_data, s1_ready : producer channel 1 stream
//   wrfull                      : FIFO write-side full flag (current cycle)
//   wrreq, data                 : FIFO write request and write data
//
// Modports:
//   master : the producers/FIFO environment (drives valids, data, wrfull)
//   slave  : the arbiter (drives readies, wrreq, data)
interface fifo_wr_arbiter_if #(
  parameter int DW = 8
);
  logic          s0_valid;
  logic [DW-1:0] s0_data;
  logic          s0_ready;
  logic          s1_valid;
  logic [DW-1:0] s1_data;
  logic          s1_ready;
  logic          wrfull;
  logic          wrreq;
  logic [DW-1:0] data;

  modport master (
    output s0_valid, s0_data, s1_valid, s1_data, wrfull,
    input  s0_ready, s1_ready, wrreq, data
  );

  modport slave (
    input  s0_valid, s0_data, s1_valid, s1_data, wrfull,
    output s0_ready, s1_ready, wrreq, data
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin arbiter sharing the single write port of a same-clock FIFO
// between two producer channels. One channel is granted at a time for a
// burst of at most BURST words; a full FIFO stalls the burst without ever
// forcing a grant switch.
//
// Parameters:
//   DW    : data width of both channels and the FIFO write port
//   BURST : maximum words accepted per grant before rotation (2..255)
//   CW    : width of the saturating per-channel accepted-word counters
//
// Ports:
//   clk  : system clock, all state on its rising edge
//   rst  : synchronous active-high reset
//   bus  : producer streams + FIFO write side (slave modport)
//   gnt  : one-hot current grant, {G1, G0}; 00 when idle
//   cnt0 : words accepted from channel 0 (saturating)
//   cnt1 : words accepted from channel 1 (saturating)
module fifo_wr_arbiter #(
  parameter int DW    = 8,
  parameter int BURST = 4,
  parameter int CW    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_wr_arbiter_if.slave     bus,
  output logic [1:0]           gnt,
  output logic [CW-1:0]        cnt0,
  output logic [CW-1:0]        cnt1
);

  localparam int BCW = (BURST > 2) ? $clog2(BURST) : 1;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BURST - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic            r_rr;
  logic            w_nextRr;
  logic [BCW-1:0]  r_bc;
  logic [BCW-1:0]  w_nextBc;
  logic [CW-1:0]   r_cnt0;
  logic [CW-1:0]   r_cnt1;

  logic            w_granted;
  logic            w_cur;
  logic            w_curValid;
  logic            w_othValid;
  logic [DW-1:0]   w_curData;
  logic            w_accept;
  logic            w_lastBeat;
  logic            w_exit;

  // Registered FSM state, round-robin pointer and beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_rr    <= 1'b0;
      r_bc    <= '0;
    end else begin
      r_state <= w_nextState;
      r_rr    <= w_nextRr;
      r_bc    <= w_nextBc;
    end
  end

  // Next-state logic and all handshake outputs. w_cur is the index of the
  // granted channel; it only has meaning while w_granted is set.
  always_comb begin
    w_nextState = r_state;
    w_nextRr    = r_rr;
    w_nextBc    = r_bc;

    w_granted  = (r_state == G0) || (r_state == G1);
    w_cur      = (r_state == G1);
    w_curValid = w_cur ? bus.s1_valid : bus.s0_valid;
    w_othValid = w_cur ? bus.s0_valid : bus.s1_valid;
    w_curData  = w_cur ? bus.s1_data  : bus.s0_data;

    // Accept is suppressed during reset so the word on the bus in the reset
    // cycle is left with its producer rather than lost.
    w_accept   = w_granted && w_curValid && !bus.wrfull && !rst;
    w_lastBeat = w_accept && (r_bc == LAST_BEAT);
    w_exit     = w_granted && (w_lastBeat || !w_curValid);

    case (r_state)
      IDLE: begin
        w_nextBc = '0;
        if (bus.s0_valid && bus.s1_valid) begin
          w_nextState = r_rr ? G1 : G0;
        end else if (bus.s0_valid) begin
          w_nextState = G0;
        end else if (bus.s1_valid) begin
          w_nextState = G1;
        end
      end
      G0, G1: begin
        if (w_exit) begin
          // Rotation always moves the pointer, even when the same channel
          // keeps the grant for a fresh burst because the other is idle.
          w_nextRr = ~w_cur;
          w_nextBc = '0;
          if (w_othValid) begin
            w_nextState = w_cur ? G0 : G1;
          end else if (w_curValid) begin
            w_nextState = r_state;
          end else begin
            w_nextState = IDLE;
          end
        end else if (w_accept) begin
          w_nextBc = r_bc + 1'b1;
        end
      end
      default: begin
        w_nextState = IDLE;
        w_nextBc    = '0;
      end
    endcase

    bus.s0_ready = w_accept && !w_cur;
    bus.s1_ready = w_accept && w_cur;
    bus.wrreq    = w_accept;
    bus.data     = w_granted ? w_curData : '0;
    gnt          = {r_state == G1, r_state == G0};
  end

  // Saturating accepted-word counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_accept && !w_cur && (r_cnt0 != {CW{1'b1}})) begin
        r_cnt0 <= r_cnt0 + 1'b1;
      end
      if (w_accept && w_cur && (r_cnt1 != {CW{1'b1}})) begin
        r_cnt1 <= r_cnt1 + 1'b1;
      end
    end
  end

  assign cnt0 = r_cnt0;
  assign cnt1 = r_cnt1;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
// Self-checking bench for fifo_wr_arbiter. Two instances run side by side on
// the same stimulus: dutA with CW=16 and dutB with CW=4 (to reach counter
// saturation quickly). Every cycle both are compared against a behavioural
// model of the grant/burst rules; a hand-derived vector table and a few
// hand-written sequences add explicit expectations on top.
module tb_fifo_wr_arbiter;

  localparam int DW       = 8;
  localparam int BURST    = 4;
  localparam int CNT_MAXA = 65535;
  localparam int CNT_MAXB = 15;

  logic        clk;
  logic        rst;
  logic [1:0]  gntA, gntB;
  logic [15:0] cnt0A, cnt1A;
  logic [3:0]  cnt0B, cnt1B;

  int checks   = 0;
  int failures = 0;

  fifo_wr_arbiter_if #(.DW(DW)) ifA ();
  fifo_wr_arbiter_if #(.DW(DW)) ifB ();

  assign ifB.s0_valid = ifA.s0_valid;
  assign ifB.s0_data  = ifA.s0_data;
  assign ifB.s1_valid = ifA.s1_valid;
  assign ifB.s1_data  = ifA.s1_data;
  assign ifB.wrfull   = ifA.wrfull;

  fifo_wr_arbiter #(.DW(DW), .BURST(BURST), .CW(16)) dutA (
    .clk  (clk),
    .rst  (rst),
    .bus  (ifA.slave),
    .gnt  (gntA),
    .cnt0 (cnt0A),
    .cnt1 (cnt1A)
  );

  fifo_wr_arbiter #(.DW(DW), .BURST(BURST), .CW(4)) dutB (
    .clk  (clk),
    .rst  (rst),
    .bus  (ifB.slave),
    .gnt  (gntB),
    .cnt0 (cnt0B),
    .cnt1 (cnt1B)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: owner -1 = nobody granted, otherwise channel index.
  int mOwner, mRr, mBeats, mCnt0, mCnt1;
  logic [1:0]    eGnt;
  logic          eWr, eR0, eR1;
  logic [DW-1:0] eData;

  function automatic int satInc(input int v, input int maxV);
    return (v >= maxV) ? maxV : v + 1;
  endfunction

  function automatic int minInt(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic void modelReset();
    mOwner = -1; mRr = 0; mBeats = 0; mCnt0 = 0; mCnt1 = 0;
  endfunction

  function automatic void modelComb();
    logic sv;
    eGnt = 2'b00; eWr = 1'b0; eR0 = 1'b0; eR1 = 1'b0; eData = '0;
    if (mOwner >= 0) begin
      sv    = (mOwner == 0) ? ifA.s0_valid : ifA.s1_valid;
      eGnt  = (mOwner == 0) ? 2'b01 : 2'b10;
      eData = (mOwner == 0) ? ifA.s0_data : ifA.s1_data;
      eWr   = sv & ~ifA.wrfull & ~rst;
      eR0   = eWr & (mOwner == 0);
      eR1   = eWr & (mOwner == 1);
    end
  endfunction

  function automatic void modelEdge();
    logic v0, v1, sv, ov;
    int other;
    v0 = ifA.s0_valid;
    v1 = ifA.s1_valid;
    if (rst) begin
      modelReset();
      return;
    end
    if (mOwner < 0) begin
      if (v0 && v1) mOwner = mRr;
      else if (v0)  mOwner = 0;
      else if (v1)  mOwner = 1;
    end else begin
      other = 1 - mOwner;
      sv = (mOwner == 0) ? v0 : v1;
      ov = (other == 0) ? v0 : v1;
      if (eWr) begin
        mBeats++;
        if (mOwner == 0) mCnt0 = satInc(mCnt0, CNT_MAXA);
        else             mCnt1 = satInc(mCnt1, CNT_MAXA);
      end
      if ((eWr && mBeats == BURST) || !sv) begin
        mRr    = other;
        mBeats = 0;
        if (ov)       mOwner = other;
        else if (!sv) mOwner = -1;
      end
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkModel();
    checkOutput("gntA",    32'(gntA),         32'(eGnt));
    checkOutput("wrreqA",  32'(ifA.wrreq),    32'(eWr));
    checkOutput("dataA",   32'(ifA.data),     32'(eData));
    checkOutput("rdy0A",   32'(ifA.s0_ready), 32'(eR0));
    checkOutput("rdy1A",   32'(ifA.s1_ready), 32'(eR1));
    checkOutput("bothRdy", 32'(ifA.s0_ready & ifA.s1_ready), 32'd0);
    checkOutput("cnt0A",   32'(cnt0A),        32'(mCnt0));
    checkOutput("cnt1A",   32'(cnt1A),        32'(mCnt1));
    checkOutput("wrreqB",  32'(ifB.wrreq),    32'(eWr));
    checkOutput("dataB",   32'(ifB.data),     32'(eData));
    checkOutput("cnt0B",   32'(cnt0B),        32'(minInt(mCnt0, CNT_MAXB)));
    checkOutput("cnt1B",   32'(cnt1B),        32'(minInt(mCnt1, CNT_MAXB)));
  endtask

  // Drive one cycle of inputs and compare at the following falling edge.
  task automatic applyStimulus(input logic v0, input logic [DW-1:0] d0,
                               input logic v1, input logic [DW-1:0] d1,
                               input logic full, input logic r);
    ifA.s0_valid = v0; ifA.s0_data = d0;
    ifA.s1_valid = v1; ifA.s1_data = d1;
    ifA.wrfull   = full;
    rst          = r;
    @(negedge clk);
    modelComb();
    checkModel();
  endtask

  task automatic stepEdge();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic doReset();
    ifA.s0_valid = 1'b0; ifA.s0_data = '0;
    ifA.s1_valid = 1'b0; ifA.s1_data = '0;
    ifA.wrfull   = 1'b0;
    rst          = 1'b1;
    @(posedge clk);
    modelReset();
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic          v0;
    logic [DW-1:0] d0;
    logic          v1;
    logic [DW-1:0] d1;
    logic          full;
    logic [1:0]    gnt;
    logic          wr;
    logic [DW-1:0] data;
    logic          r0;
    logic          r1;
    logic [15:0]   cnt0;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [DW-1:0] w0, w1;
    logic v0, v1, full, r;
    int got;

    //              v0    d0     v1    d1     full  gnt    wr    data   r0    r1    cnt0
    vecs[0]  = '{1'b1, 8'h01, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 16'd0};
    vecs[1]  = '{1'b1, 8'h01, 1'b0, 8'h00, 1'b0, 2'b01, 1'b1, 8'h01, 1'b1, 1'b0, 16'd0};
    vecs[2]  = '{1'b1, 8'h02, 1'b1, 8'hB0, 1'b0, 2'b01, 1'b1, 8'h02, 1'b1, 1'b0, 16'd1};
    vecs[3]  = '{1'b1, 8'h03, 1'b1, 8'hB0, 1'b1, 2'b01, 1'b0, 8'h03, 1'b0, 1'b0, 16'd2};
    vecs[4]  = '{1'b1, 8'h03, 1'b1, 8'hB0, 1'b0, 2'b01, 1'b1, 8'h03, 1'b1, 1'b0, 16'd2};
    vecs[5]  = '{1'b1, 8'h04, 1'b1, 8'hB0, 1'b0, 2'b01, 1'b1, 8'h04, 1'b1, 1'b0, 16'd3};
    vecs[6]  = '{1'b1, 8'h05, 1'b1, 8'hB0, 1'b0, 2'b10, 1'b1, 8'hB0, 1'b0, 1'b1, 16'd4};
    vecs[7]  = '{1'b1, 8'h05, 1'b0, 8'hB1, 1'b0, 2'b10, 1'b0, 8'hB1, 1'b0, 1'b0, 16'd4};
    vecs[8]  = '{1'b1, 8'h05, 1'b0, 8'h00, 1'b0, 2'b01, 1'b1, 8'h05, 1'b1, 1'b0, 16'd4};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 2'b01, 1'b0, 8'h00, 1'b0, 1'b0, 16'd5};
    vecs[10] = '{1'b1, 8'h06, 1'b1, 8'hB2, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 16'd5};
    vecs[11] = '{1'b1, 8'h06, 1'b1, 8'hB2, 1'b0, 2'b10, 1'b1, 8'hB2, 1'b0, 1'b1, 16'd5};

    $display("[TB] start");
    doReset();

    // Table: stall on wrfull, burst rotation, drop exit, idle re-arbitration.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].v0, vecs[i].d0, vecs[i].v1, vecs[i].d1, vecs[i].full, 1'b0);
      checkOutput($sformatf("vec%0d_gnt", i),  32'(gntA),         32'(vecs[i].gnt));
      checkOutput($sformatf("vec%0d_wr", i),   32'(ifA.wrreq),    32'(vecs[i].wr));
      checkOutput($sformatf("vec%0d_data", i), 32'(ifA.data),     32'(vecs[i].data));
      checkOutput($sformatf("vec%0d_r0", i),   32'(ifA.s0_ready), 32'(vecs[i].r0));
      checkOutput($sformatf("vec%0d_r1", i),   32'(ifA.s1_ready), 32'(vecs[i].r1));
      checkOutput($sformatf("vec%0d_cnt0", i), 32'(cnt0A),        32'(vecs[i].cnt0));
      stepEdge();
    end

    // Reset during the third beat of a G1 burst.
    applyStimulus(1'b1, 8'h06, 1'b1, 8'hB3, 1'b0, 1'b0);
    checkOutput("midrst_beat2_wr", 32'(ifA.wrreq), 32'd1);
    stepEdge();
    applyStimulus(1'b1, 8'h06, 1'b1, 8'hB4, 1'b0, 1'b1);
    checkOutput("midrst_rstcycle_wr", 32'(ifA.wrreq), 32'd0);
    stepEdge();
    applyStimulus(1'b1, 8'hC0, 1'b1, 8'hD0, 1'b0, 1'b0);
    checkOutput("midrst_gnt",  32'(gntA),      32'd0);
    checkOutput("midrst_wr",   32'(ifA.wrreq), 32'd0);
    checkOutput("midrst_cnt0", 32'(cnt0A),     32'd0);
    checkOutput("midrst_cnt1", 32'(cnt1A),     32'd0);
    stepEdge();
    applyStimulus(1'b1, 8'hC0, 1'b1, 8'hD0, 1'b0, 1'b0);
    checkOutput("midrst_firstgnt", 32'(gntA),     32'd1);
    checkOutput("midrst_firstdat", 32'(ifA.data), 32'hC0);
    stepEdge();

    // Single-channel stream of 20 words: CW=4 counter saturates at 15.
    doReset();
    got = 0;
    for (int c = 0; c < 21; c++) begin
      applyStimulus(1'b1, 8'(got + 1), 1'b0, 8'h00, 1'b0, 1'b0);
      if (ifB.wrreq) begin
        checkOutput($sformatf("stream_word%0d", got), 32'(ifB.data), 32'(got + 1));
        got++;
      end
      stepEdge();
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("stream_count", 32'(got),   32'd20);
    checkOutput("stream_cnt0B", 32'(cnt0B), 32'd15);
    checkOutput("stream_cnt0A", 32'(cnt0A), 32'd20);
    stepEdge();

    // Randomized producers, backpressure and occasional reset vs the model.
    doReset();
    w0 = 8'hA0;
    w1 = 8'hB0;
    for (int c = 0; c < 1500; c++) begin
      v0   = ($urandom_range(0, 3) != 0);
      v1   = ($urandom_range(0, 3) != 0);
      full = ($urandom_range(0, 4) == 0);
      r    = ($urandom_range(0, 99) == 0);
      applyStimulus(v0, w0, v1, w1, full, r);
      if (eR0) w0 = w0 + 8'd1;
      if (eR1) w1 = w1 + 8'd1;
      stepEdge();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin arbiter that shares the single write port of the same-clock 8-bit FIFO between two producer channels. Each producer presents a valid/ready stream. The arbiter grants one channel at a time for a burst of at most BURST words, stalls on `wrfull`, and drives `wrreq`/`data` into the FIFO. It sits between the producers and the FIFO write side; the read side is untouched.

## Interface
- DW, 8, data width of the FIFO write port and both channels
- BURST, 4, maximum words accepted per grant before rotation (2..255)
- CW, 16, width of the per-channel accepted-word counters

- clk  in  1  single system clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- s0_valid  in  1  channel 0 has a word
- s0_data  in  DW  channel 0 word
- s0_ready  out  1  channel 0 word accepted this cycle
- s1_valid  in  1  channel 1 has a word
- s1_data  in  DW  channel 1 word
- s1_ready  out  1  channel 1 word accepted this cycle
- wrfull  in  1  FIFO write-side full flag
- wrreq  out  1  FIFO write request
- data  out  DW  FIFO write data
- gnt  out  2  one-hot current grant (00 = idle)
- cnt0  out  CW  words accepted from channel 0, saturating
- cnt1  out  CW  words accepted from channel 1, saturating

## Operation
- FSM states: IDLE, G0, G1. `gnt` = {state==G1, state==G0}.
- Round-robin pointer `rr` names the preferred next channel.
- IDLE:
  - If both valid, go to G[rr].
  - If one valid, go to that channel.
  - If none valid, stay.
  - The transition is registered, so a grant is always at least one cycle after valid first rises.
- In Gx:
  - accept = sx_valid & ~wrfull.
  - sx_ready = accept.
  - wrreq = accept.
  - data = sx_data, muxed combinationally.
  - The other channel's ready is 0.
- Beat counter `bc` (width ceil(log2 BURST)) increments on each accept and is cleared on every grant entry.
- Gx exit conditions, evaluated each cycle:
  - (a) accept and bc==BURST-1 (burst complete).
  - (b) sx_valid==0 (channel dropped; no accept this cycle).
- On exit:
  - rr ← other channel.
  - Next state is G[other] if the other channel is valid; else Gx again (new burst, bc cleared) if sx_valid is still high under (a); else IDLE.
- wrfull in Gx: no accept, bc holds, no rotation while sx_valid stays high. A full FIFO never causes a grant switch.
- Outside Gx, wrreq=0, both ready=0, and data = 0.
- cnt0/cnt1 increment by 1 on each accept of their channel and saturate at 2^CW-1.
- Words are never dropped or duplicated. A word is consumed only in a cycle where sx_valid & sx_ready.

## Timing
- Reset (rst high at a clock edge): state=IDLE, rr=0, bc=0, cnt0=cnt1=0, gnt=00, wrreq=0, s0_ready=s1_ready=0, data=0.
- Reset mid-burst aborts the burst. The word on the bus in the reset cycle is not accepted.
- Latency, valid to first accept:
  - 1 cycle from IDLE.
  - 0 cycles if already granted.
- Sustained throughput is 1 word/cycle within a burst.
- A rotation between valid channels costs no bubble. Exit on valid drop costs that one cycle.
- Simultaneous first valid on both channels from IDLE goes to channel rr.
- wrfull is sampled combinationally in the same cycle as wrreq. The FIFO must present wrfull for the current cycle.

## Test plan
- Reset, then s0 streams 0x01..0x0A continuously, s1 idle, BURST=4 → gnt=01 from cycle 1; wrreq high 10 consecutive cycles, data 0x01..0x0A in order; rr toggles every 4 words but the grant stays G0 with no bubble; cnt0=10, cnt1=0.
- Both channels valid continuously from reset (s0 0xA0.., s1 0xB0..), BURST=4 → G0 first (rr=0); FIFO receives A0–A3, B0–B3, A4–A7 with no idle cycle between bursts; ready never high on both channels.
- s0 streaming in G0, wrfull forced high for 3 cycles after its 2nd word → wrreq=0, s0_ready=0 for 3 cycles, grant held, bc held at 2; after release, words 3–4 are written, then rotation to s1.
- s0 valid drops after 2 words while s1 is valid → the drop cycle has no accept; next cycle gnt=10 and the s1 burst starts; cnt0=2.
- rst asserted in the 3rd beat of a G1 burst → next cycle gnt=00, wrreq=0, cnt0=cnt1=0, rr=0; with both valid afterward, the first grant is G0.
- CW=4, s0 streams 20 words → cnt0 reaches 15 and holds; all 20 words still reach the FIFO in order.
